bl_row_writer: RTL and testbench



---
 rtl/bl_row_if.sv | 26 ++
 rtl/bl_row_writer.sv | 120 ++++++++++++
 tb/tb_bl_row_writer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bl_row_if.sv
// bl_row_if: row-capture handshake and zone RAM write port of the backlight row writer
interface bl_row_if #(
    parameter int ZONES_H = 24,
    parameter int DATA_W  = 8,
    parameter int V_W     = 4,
    parameter int H_W     = 5
);
    logic                      iStart;
    logic [V_W-1:0]            iV_address;
    logic [ZONES_H*DATA_W-1:0] iBlockData;
    logic                      oBusy;
    logic                      oDone;
    logic                      oWEA;
    logic [DATA_W-1:0]         oData;
    logic [V_W+H_W-1:0]        oAddress;

    modport master (
        output iStart, iV_address, iBlockData,
        input  oBusy, oDone, oWEA, oData, oAddress
    );

    modport slave (
        input  iStart, iV_address, iBlockData,
        output oBusy, oDone, oWEA, oData, oAddress
    );
endinterface

// File: rtl/bl_row_writer.sv
// bl_row_writer: writes one captured row of zone levels into the zone RAM at {row, zone}; BL_MIN_CLAMP_EN enables a MIN_LEVEL floor on written levels
module bl_row_writer #(
    parameter int ZONES_H    = 24,
    parameter int DATA_W     = 8,
    parameter int V_W        = 4,
    parameter int H_W        = 5,
    parameter int WR_SPACING = 3,
    parameter int SKIP_ROW   = 15,
    parameter int MIN_LEVEL  = 0
) (
    input logic   iODCK,
    input logic   iRST,
    bl_row_if.slave bus
);
    localparam int SP_W = $clog2(WR_SPACING + 1);
    localparam logic [H_W-1:0]  H_LAST  = H_W'(ZONES_H - 1);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(WR_SPACING - 1);
    localparam logic [V_W-1:0]  SKIP    = V_W'(SKIP_ROW);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, GAP, DONE} state_t;

    state_t                    state_q, state_d;
    logic [V_W-1:0]            row_q, row_d;
    logic [ZONES_H*DATA_W-1:0] blk_q, blk_d;
    logic [H_W-1:0]            h_q, h_d;
    logic [SP_W-1:0]           sp_q, sp_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      wea_q, wea_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [V_W+H_W-1:0]        addr_q, addr_d;
    logic                      adv;
    logic [DATA_W-1:0]         lvl_raw;
    logic [DATA_W-1:0]         lvl;

    // State register, captured row and registered RAM-side outputs
    always_ff @(posedge iODCK) begin
        if (iRST) begin
            state_q <= IDLE;
            row_q   <= '0;
            blk_q   <= '0;
            h_q     <= '0;
            sp_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wea_q   <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
            h_q     <= h_d;
            sp_q    <= sp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wea_q   <= wea_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Next state, zone/slot counters, and outputs derived from the state being entered
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        blk_d   = blk_q;
        h_d     = h_q;
        sp_d    = sp_q;
        adv     = (state_q == WRITE && WR_SPACING == 1) || (state_q == GAP && sp_q == SP_LAST);
        unique case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    state_d = LOAD;
                    row_d   = bus.iV_address;
                    blk_d   = bus.iBlockData;
                end
            end
            LOAD: begin
                h_d     = '0;
                sp_d    = '0;
                state_d = (row_q == SKIP) ? DONE : WRITE;
            end
            WRITE: begin
                sp_d = SP_W'(1);
                if (WR_SPACING > 1) state_d = GAP;
            end
            GAP: begin
                if (sp_q != SP_LAST) sp_d = sp_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (adv) begin
            state_d = (h_q == H_LAST) ? DONE : WRITE;
            h_d     = (h_q == H_LAST) ? h_q : h_q + 1'b1;
        end
        lvl_raw = blk_q[h_d*DATA_W +: DATA_W];
`ifdef BL_MIN_CLAMP_EN
        lvl     = (lvl_raw < DATA_W'(MIN_LEVEL)) ? DATA_W'(MIN_LEVEL) : lvl_raw;
`else
        lvl     = lvl_raw;
`endif
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        wea_d   = state_d == WRITE;
        addr_d  = (state_d == WRITE) ? {row_q, h_d} : (state_d == GAP) ? addr_q : '0;
        data_d  = (state_d == WRITE) ? lvl : (state_d == GAP) ? data_q : '0;
    end

    assign bus.oBusy    = busy_q;
    assign bus.oDone    = done_q;
    assign bus.oWEA     = wea_q;
    assign bus.oData    = data_q;
    assign bus.oAddress = addr_q;
endmodule

// File: tb/tb_bl_row_writer.sv
// tb_bl_row_writer: directed checks of the backlight row writer at default and single-cycle spacing
module tb_bl_row_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bl_row_if #(.ZONES_H(24)) a ();
    bl_row_if #(.ZONES_H(4))  b ();

    bl_row_writer #(.MIN_LEVEL('h20)) dut_a (.iODCK(clk), .iRST(rst), .bus(a));
    bl_row_writer #(.ZONES_H(4), .WR_SPACING(1), .MIN_LEVEL('h20)) dut_b (.iODCK(clk), .iRST(rst), .bus(b));

    wire [19:0] obs_a = {a.oBusy, a.oDone, a.oWEA, a.oData, a.oAddress};
    wire [19:0] obs_b = {b.oBusy, b.oDone, b.oWEA, b.oData, b.oAddress};

    function automatic logic [7:0] lvl(input logic [7:0] x);
`ifdef BL_MIN_CLAMP_EN
        return (x < 8'h20) ? 8'h20 : x;
`else
        return x;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a.iStart = 1'b1;
        b.iStart = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_a !== 20'h0) begin failures++; $display("FAIL reset_a: got %h want 00000", obs_a); end
        checks++;
        if (obs_b !== 20'h0) begin failures++; $display("FAIL reset_b: got %h want 00000", obs_b); end
        rst = 1'b0;
        a.iStart = 1'b0;
        b.iStart = 1'b0;
        tick();
        checks++;
        if (a.oBusy !== 1'b0) begin failures++; $display("FAIL reset_start_dropped: busy=%b want 0", a.oBusy); end
    endtask

    task automatic test_basic_row;
        logic [19:0] exp;
        a.iV_address = 4'd3;
        for (int h = 0; h < 24; h++) a.iBlockData[h*8 +: 8] = 8'(h + 1);
        a.iStart = 1'b1;
        tick();
        a.iStart = 1'b0;
        checks++;
        if (obs_a !== {3'b100, 17'h0}) begin failures++; $display("FAIL basic_load: got %h want %h", obs_a, {3'b100, 17'h0}); end
        for (int k = 1; k <= 74; k++) begin
            tick();
            if (k <= 72) exp = {1'b1, 1'b0, ((k - 1) % 3) == 0, lvl(8'((k - 1) / 3 + 1)), 4'd3, 5'((k - 1) / 3)};
            else if (k == 73) exp = {3'b110, 17'h0};
            else exp = 20'h0;
            checks++;
            if (obs_a !== exp) begin failures++; $display("FAIL basic_cycle E%0d: got %h want %h", k, obs_a, exp); end
        end
    endtask

    task automatic test_spacing1;
        logic [19:0] exp;
        b.iV_address = 4'd1;
        for (int h = 0; h < 4; h++) b.iBlockData[h*8 +: 8] = 8'(8'h30 + h);
        b.iStart = 1'b1;
        tick();
        b.iStart = 1'b0;
        checks++;
        if (obs_b !== {3'b100, 17'h0}) begin failures++; $display("FAIL sp1_load: got %h want %h", obs_b, {3'b100, 17'h0}); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) exp = {3'b101, lvl(8'(8'h30 + k - 1)), 4'd1, 5'(k - 1)};
            else if (k == 5) exp = {3'b110, 17'h0};
            else exp = 20'h0;
            checks++;
            if (obs_b !== exp) begin failures++; $display("FAIL sp1_cycle E%0d: got %h want %h", k, obs_b, exp); end
        end
    endtask

    task automatic test_skip_row;
        a.iV_address = 4'd15;
        a.iStart = 1'b1;
        tick();
        a.iStart = 1'b0;
        checks++;
        if (obs_a !== {3'b100, 17'h0}) begin failures++; $display("FAIL skip_E0: got %h want %h", obs_a, {3'b100, 17'h0}); end
        tick();
        checks++;
        if (obs_a !== {3'b110, 17'h0}) begin failures++; $display("FAIL skip_E1: got %h want %h", obs_a, {3'b110, 17'h0}); end
        tick();
        checks++;
        if (obs_a !== 20'h0) begin failures++; $display("FAIL skip_E2: got %h want 00000", obs_a); end
    endtask

    task automatic test_reset_mid;
        int writes = 0;
        int dones = 0;
        int n = 0;
        logic [19:0] exp;
        a.iV_address = 4'd5;
        for (int h = 0; h < 24; h++) a.iBlockData[h*8 +: 8] = 8'(h + 1);
        a.iStart = 1'b1;
        tick();
        a.iStart = 1'b0;
        repeat (31) tick();
        exp = {3'b101, lvl(8'h0B), 4'd5, 5'd10};
        checks++;
        if (obs_a !== exp) begin failures++; $display("FAIL mid_zone10: got %h want %h", obs_a, exp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs_a !== 20'h0) begin failures++; $display("FAIL mid_reset: got %h want 00000", obs_a); end
        repeat (80) begin
            tick();
            writes += int'(a.oWEA);
            dones += int'(a.oDone);
        end
        checks++;
        if (writes !== 0 || dones !== 0) begin failures++; $display("FAIL mid_quiet: writes=%0d dones=%0d want 0 0", writes, dones); end
        a.iV_address = 4'd2;
        a.iStart = 1'b1;
        tick();
        a.iStart = 1'b0;
        tick();
        exp = {3'b101, lvl(8'h01), 4'd2, 5'd0};
        checks++;
        if (obs_a !== exp) begin failures++; $display("FAIL mid_restart: got %h want %h", obs_a, exp); end
        while (a.oBusy && n < 100) begin tick(); n++; end
        checks++;
        if (a.oBusy !== 1'b0) begin failures++; $display("FAIL mid_finish: busy=%b want 0 within 100 cycles", a.oBusy); end
    endtask

    task automatic test_back_to_back;
        int writes = 0;
        int dones = 0;
        int n = 0;
        a.iV_address = 4'd4;
        a.iStart = 1'b1;
        tick();
        checks++;
        if (a.oBusy !== 1'b1) begin failures++; $display("FAIL b2b_accept: busy=%b want 1", a.oBusy); end
        repeat (73) begin
            tick();
            writes += int'(a.oWEA);
            dones += int'(a.oDone);
        end
        checks++;
        if (writes !== 24 || dones !== 1) begin failures++; $display("FAIL b2b_row1: writes=%0d dones=%0d want 24 1", writes, dones); end
        tick();
        checks++;
        if (a.oBusy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: busy=%b want 0", a.oBusy); end
        tick();
        checks++;
        if (a.oBusy !== 1'b1) begin failures++; $display("FAIL b2b_restart: busy=%b want 1", a.oBusy); end
        a.iStart = 1'b0;
        writes = 0;
        while (a.oBusy && n < 100) begin tick(); writes += int'(a.oWEA); n++; end
        checks++;
        if (writes !== 24 || a.oBusy !== 1'b0) begin failures++; $display("FAIL b2b_row2: writes=%0d busy=%b want 24 0", writes, a.oBusy); end
    endtask

    task automatic test_clamp;
        logic [7:0] exp0;
        int n = 0;
`ifdef BL_MIN_CLAMP_EN
        exp0 = 8'h20;
`else
        exp0 = 8'h05;
`endif
        a.iV_address = 4'd0;
        a.iBlockData = '0;
        a.iBlockData[7:0] = 8'h05;
        a.iBlockData[15:8] = 8'h40;
        a.iStart = 1'b1;
        tick();
        a.iStart = 1'b0;
        tick();
        checks++;
        if (a.oWEA !== 1'b1 || a.oData !== exp0) begin failures++; $display("FAIL clamp_zone0: wea=%b data=%h want 1 %h", a.oWEA, a.oData, exp0); end
        repeat (3) tick();
        checks++;
        if (a.oWEA !== 1'b1 || a.oData !== 8'h40 || a.oAddress !== 9'h001) begin
            failures++;
            $display("FAIL clamp_zone1: wea=%b data=%h addr=%h want 1 40 001", a.oWEA, a.oData, a.oAddress);
        end
        while (a.oBusy && n < 100) begin tick(); n++; end
        checks++;
        if (a.oBusy !== 1'b0) begin failures++; $display("FAIL clamp_finish: busy=%b want 0 within 100 cycles", a.oBusy); end
    endtask

    initial begin
        a.iStart = 1'b0;
        a.iV_address = '0;
        a.iBlockData = '0;
        b.iStart = 1'b0;
        b.iV_address = '0;
        b.iBlockData = '0;
        test_reset();
        test_basic_row();
        test_spacing1();
        test_skip_row();
        test_reset_mid();
        test_back_to_back();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
